// File: rtl/id_ex_trace_receiver.sv
// ID -> EX trace element receiver: circular queue for EX pulls, a bypass path for
// pass-through elements, and sticky drop / timestamp-order flags.
package id_ex_trace_pkg;
    typedef logic [31:0] stamp_t;

    typedef struct packed {
        stamp_t time_start;
        stamp_t time_end;
    } stage_time_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        pass_through;
        stage_time_t if_data;
        stage_time_t id_data;
        stage_time_t ex_data;
        stage_time_t wb_data;
    } trace_format_t;
endpackage

module id_ex_trace_receiver #(
    parameter int  TRACE_BUFFER_SIZE = 32,
    parameter int  COUNT_WIDTH       = 16,
    parameter type trace_format      = id_ex_trace_pkg::trace_format_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_data_ready,
    input  trace_format            id_data_i,
    input  logic                   data_request,
    output logic                   data_present,
    output trace_format            trace_element_out,
    output logic                   pass_through_valid,
    output trace_format            pass_through_o,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] dropped_count,
    output logic                   order_error
);
    localparam int PTR_W = $clog2(TRACE_BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    trace_format              r_mem [TRACE_BUFFER_SIZE];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_data_present;
    trace_format              r_trace_element;
    logic                     r_pt_valid;
    trace_format              r_pt_data;
    logic                     r_overflow;
    logic [COUNT_WIDTH-1:0]   r_dropped;
    logic                     r_order_error;
    id_ex_trace_pkg::stamp_t  r_last_id_end;

    logic                     w_accept;
    logic                     w_bypass;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_write;
    logic                     w_drop;
    logic [CNT_W-1:0]         w_count_nxt;

    assign w_accept    = id_data_ready && !id_data_i.pass_through;
    assign w_bypass    = id_data_ready &&  id_data_i.pass_through;
    assign w_pop       = data_request && r_data_present;
    assign w_full      = (r_count == CNT_W'(TRACE_BUFFER_SIZE));
    // A pop in the same cycle frees the head slot, so a full queue can still take the write.
    assign w_write     = w_accept && (!w_full || w_pop);
    assign w_drop      = w_accept && w_full && !w_pop;
    assign w_count_nxt = r_count + CNT_W'(w_write) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= id_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_data_present  <= 1'b0;
            r_trace_element <= '{default:0};
            r_pt_valid      <= 1'b0;
            r_pt_data       <= '{default:0};
            r_overflow      <= 1'b0;
            r_dropped       <= '0;
            r_order_error   <= 1'b0;
            r_last_id_end   <= '0;
        end else begin
            r_count        <= w_count_nxt;
            r_data_present <= (w_count_nxt != '0);
            r_pt_valid     <= w_bypass;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_trace_element <= r_mem[r_rd_ptr];
                r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
            end
            if (w_bypass) begin
                r_pt_data <= id_data_i;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != '1) begin
                    r_dropped <= r_dropped + COUNT_WIDTH'(1);
                end
            end
            // Only the queued stream is order-checked; bypassed elements are reordered downstream.
            if (w_accept) begin
                if (id_data_i.id_data.time_start < r_last_id_end) begin
                    r_order_error <= 1'b1;
                end
                r_last_id_end <= id_data_i.id_data.time_end;
            end
        end
    end

    assign data_present       = r_data_present;
    assign trace_element_out  = r_trace_element;
    assign pass_through_valid = r_pt_valid;
    assign pass_through_o     = r_pt_data;
    assign overflow           = r_overflow;
    assign dropped_count      = r_dropped;
    assign order_error        = r_order_error;
endmodule
